imm_gen_stage: RTL

Registered, parametrised immediate generator for the decode stage. It decodes the RISC-V format directly from the opcode (no external `imm_type`), produces an XLEN-wide immediate with correct U/J placement and shift-amount handling, and flags unsupported encodings. The block sits between the IF/ID register and the register-file read/issue logic. It uses a valid/ready handshake with a 2-entry skid buffer and a synchronous flush.

---
 rtl/imm_gen_if.sv | 27 ++
 rtl/imm_gen_stage.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/imm_gen_if.sv
// Handshake and payload bundle for the decode-stage immediate generator.
// master = upstream/downstream driver side, slave = the imm_gen_stage block.
interface imm_gen_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, instr, in_tag, out_ready,
        input  in_ready, out_valid, imm, fmt, illegal, out_tag
    );

    modport slave (
        input  in_valid, instr, in_tag, out_ready,
        output in_ready, out_valid, imm, fmt, illegal, out_tag
    );
endinterface

// File: rtl/imm_gen_stage.sv
// Registered RISC-V immediate generator: opcode-driven format decode feeding a
// main output register backed by one skid entry, with synchronous flush.
module imm_gen_stage #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    imm_gen_if.slave    bus
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

    typedef enum logic [2:0] {
        FMT_I   = 3'b000,
        FMT_S   = 3'b001,
        FMT_B   = 3'b010,
        FMT_U   = 3'b011,
        FMT_J   = 3'b100,
        FMT_R   = 3'b101,
        FMT_ILL = 3'b111
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    state_e state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t incoming;
    logic   in_rdy, out_vld, accept, take;

    // Every format is first built as a 32-bit value; widening to XLEN is a
    // single sign extension from bit 31, which keeps U never above bit 31.
    function automatic entry_t decode(input logic [31:0] ins, input logic [TAG_W-1:0] tag);
        entry_t     e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [31:0] v;
        logic       is_shift;
        op       = ins[6:0];
        f3       = ins[14:12];
        is_shift = (f3 == 3'b001) || (f3 == 3'b101);
        v        = '0;
        e.tag     = tag;
        e.illegal = 1'b0;
        e.fmt     = FMT_I;
        case (op)
            7'b0000011, 7'b1100111, 7'b1110011:
                v = {{20{ins[31]}}, ins[31:20]};
            7'b0010011: begin
                if (is_shift)
                    v = (XLEN == 64) ? {26'b0, ins[25:20]} : {27'b0, ins[24:20]};
                else
                    v = {{20{ins[31]}}, ins[31:20]};
            end
            7'b0011011: begin
                if (XLEN == 32) begin
                    e.illegal = 1'b1;
                    e.fmt     = FMT_ILL;
                end else if (is_shift) begin
                    v = {27'b0, ins[24:20]};
                end else begin
                    v = {{20{ins[31]}}, ins[31:20]};
                end
            end
            7'b0100011: begin
                e.fmt = FMT_S;
                v     = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            7'b1100011: begin
                e.fmt = FMT_B;
                v     = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                e.fmt = FMT_U;
                v     = {ins[31:12], 12'b0};
            end
            7'b1101111: begin
                e.fmt = FMT_J;
                v     = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            7'b0110011:
                e.fmt = FMT_R;
            7'b0111011: begin
                if (XLEN == 32) begin
                    e.illegal = 1'b1;
                    e.fmt     = FMT_ILL;
                end else begin
                    e.fmt = FMT_R;
                end
            end
            default: begin
                e.illegal = 1'b1;
                e.fmt     = FMT_ILL;
            end
        endcase
        e.imm = XLEN'($signed(v));
        return e;
    endfunction

    assign incoming = decode(bus.instr, bus.in_tag);
    assign in_rdy   = (state_q != FULL);
    assign out_vld  = (state_q != EMPTY);
    assign accept   = bus.in_valid && in_rdy;
    assign take     = out_vld && bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = incoming;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && take) begin
                        main_d = incoming;
                    end else if (accept) begin
                        skid_d  = incoming;
                        state_d = FULL;
                    end else if (take) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (take) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.imm       = main_q.imm;
    assign bus.fmt       = main_q.fmt;
    assign bus.illegal   = main_q.illegal;
    assign bus.out_tag   = main_q.tag;

endmodule
